alu_logic_sched: RTL and testbench

Scheduler that shares one 32-bit bitwise logic unit (NOT/AND/OR, plus two-cycle NEG built from NOT then +1) between two requesters in the ALU.
- Arbitrates round-robin and accepts one operation at a time.
- Sequences the multi-cycle NEG op.
- Returns a registered result tagged with the requester id, under valid/ready backpressure.

---
 rtl/alu_logic_pkg.sv | 21 ++
 rtl/alu_logic_sched_if.sv | 44 ++++
 rtl/alu_logic_unit.sv | 29 ++
 rtl/alu_logic_sched.sv | 119 +++++++++++
 tb/tb_alu_logic_sched.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_logic_pkg.sv
// -----------------------------------------------------------------------------
// alu_logic_pkg
// Shared definitions for the logic-unit scheduler:
//   - opcode encodings for NOT/AND/OR/NEG
//   - FSM state encoding used by alu_logic_sched
// No ports; imported by the unit, the interface users and the top.
// -----------------------------------------------------------------------------
package alu_logic_pkg;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEG2 = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_logic_sched_if.sv
// -----------------------------------------------------------------------------
// alu_logic_sched_if
// Bundles the two requester channels, the response channel and the busy flag.
//   req_valid[1:0]  requester i has an operation pending
//   req_ready[1:0]  scheduler accepts from requester i (one-hot or zero)
//   req_op0/1       opcode per requester
//   req_a0/1, b0/1  operands per requester
//   rsp_valid/ready result handshake
//   rsp_id          requester that issued the result
//   rsp_data        result value
//   busy            scheduler is not idle
// master: requester/consumer side.  slave: the scheduler.
// -----------------------------------------------------------------------------
interface alu_logic_sched_if #(
  parameter int WIDTH = 32
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_op0;
  logic [1:0]       req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/alu_logic_unit.sv
// -----------------------------------------------------------------------------
// alu_logic_unit
// Purely combinational WIDTH-bit bitwise unit.
//   i_op      opcode (OP_AND, OP_OR, anything else -> NOT of A)
//   i_a, i_b  operands
//   o_result  bitwise result
// The NEG operation reuses the NOT path; the +1 happens in the scheduler.
// -----------------------------------------------------------------------------
module alu_logic_unit
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  always_comb begin
    o_result = ~i_a;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      default: o_result = ~i_a;
    endcase
  end

endmodule

// File: rtl/alu_logic_sched.sv
// -----------------------------------------------------------------------------
// alu_logic_sched
// Shares one alu_logic_unit between two requesters with round-robin
// arbitration, one operation in flight at a time, and a registered,
// id-tagged response under valid/ready backpressure. NEG is done in two
// cycles: NOT through the unit, then +1 on the result register.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_logic_sched_if.slave (request, response and busy signals)
// -----------------------------------------------------------------------------
module alu_logic_sched
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_logic_sched_if.slave   bus
);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_lastGrant;
  logic [WIDTH-1:0] r_rspData;
  logic             r_rspId;

  logic             w_grant;
  logic [1:0]       w_reqReady;
  logic             w_accept;
  logic [1:0]       w_selOp;
  logic [1:0]       w_unitOp;
  logic [WIDTH-1:0] w_selA;
  logic [WIDTH-1:0] w_selB;
  logic [WIDTH-1:0] w_unitResult;

  // Round-robin pick: a lone requester wins outright, a tie goes to the
  // requester that was not served last.
  always_comb begin
    w_grant = ~r_lastGrant;
    case (bus.req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      default: w_grant = ~r_lastGrant;
    endcase
  end

  assign w_selOp  = w_grant ? bus.req_op1 : bus.req_op0;
  assign w_selA   = w_grant ? bus.req_a1  : bus.req_a0;
  assign w_selB   = w_grant ? bus.req_b1  : bus.req_b0;
  assign w_unitOp = (w_selOp == OP_NEG) ? OP_NOT : w_selOp;

  alu_logic_unit #(.WIDTH(WIDTH)) u_unit (
    .i_op     (w_unitOp),
    .i_a      (w_selA),
    .i_b      (w_selB),
    .o_result (w_unitResult)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and request-side ready. Ready is only offered in IDLE and is
  // held low during reset so nothing can be accepted while rst_n is low.
  always_comb begin
    w_nextState = r_state;
    w_reqReady  = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (rst_n && bus.req_valid[w_grant]) begin
          w_reqReady[w_grant] = 1'b1;
          w_nextState = (w_selOp == OP_NEG) ? S_NEG2 : S_RESP;
        end
      end
      S_NEG2: begin
        w_nextState = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign w_accept = |w_reqReady;

  // Result, id and arbitration history. The NEG2 cycle completes the
  // two's-complement by incrementing the stored NOT result; the carry out
  // of the top bit is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspData   <= '0;
      r_rspId     <= 1'b0;
      r_lastGrant <= 1'b1;
    end else if (w_accept) begin
      r_rspData   <= w_unitResult;
      r_rspId     <= w_grant;
      r_lastGrant <= w_grant;
    end else if (r_state == S_NEG2) begin
      r_rspData   <= r_rspData + WIDTH'(1);
    end
  end

  assign bus.req_ready = w_reqReady;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_rspId;
  assign bus.rsp_data  = r_rspData;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_logic_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_logic_sched
// Self-checking bench for alu_logic_sched: a vector table of single requests,
// hand-written sequences for arbitration, backpressure and reset, and a
// scoreboard queue that is filled on accept and drained on response.
// -----------------------------------------------------------------------------
module tb_alu_logic_sched;
  import alu_logic_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_logic_sched_if #(.WIDTH(WIDTH)) bus ();

  alu_logic_sched #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] data;
    int               firstCyc;
  } exp_t;

  typedef struct {
    logic             idx;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] expData;
    int               lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prevValid = 1'b0;

  // Cycle counter used to measure accept-to-response latency.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every cycle with rsp_valid is compared against the
  // oldest outstanding expectation; the entry retires when rsp_ready is high.
  initial forever begin
    @(negedge clk);
    if (rst_n !== 1'b1) begin
      prevValid = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        checkOutput("req_ready while rsp pending", WIDTH'(bus.req_ready), '0);
        if (sb.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("[TB] FAIL spurious rsp: actual id=%0d data=0x%0h required none", bus.rsp_id, bus.rsp_data);
        end else begin
          if (!prevValid) checkOutput("latency cycle", WIDTH'(cyc), WIDTH'(sb[0].firstCyc));
          checkOutput("rsp_data", bus.rsp_data, sb[0].data);
          checkOutput("rsp_id", WIDTH'(bus.rsp_id), WIDTH'(sb[0].id));
          if (bus.rsp_ready) void'(sb.pop_front());
        end
      end
      prevValid = bus.rsp_valid;
    end
  end

  // Drive one request from requester idx and push its expectation on accept.
  task automatic applyStimulus(input logic idx, input logic [1:0] op,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] expData, input int lat);
    bit done = 1'b0;
    @(posedge clk); #1;
    if (idx == 1'b0) begin
      bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
    end else begin
      bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
    end
    bus.req_valid[idx] = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin
        sb.push_back('{id: idx, data: expData, firstCyc: cyc + lat});
        done = 1'b1;
      end
    end
    if (!done) checkOutput("accept timeout", '0, 1);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  // Both requesters valid (AND on 0, OR on 1); grants must alternate.
  task automatic applyBoth(input int n, input logic firstGrant);
    logic expG = firstGrant;
    @(posedge clk); #1;
    bus.req_op0 = OP_AND; bus.req_a0 = 32'hFF00FF00; bus.req_b0 = 32'h0FF00FF0;
    bus.req_op1 = OP_OR;  bus.req_a1 = 32'hFF00FF00; bus.req_b1 = 32'h0FF00FF0;
    bus.req_valid = 2'b11;
    for (int t = 0; t < n; t++) begin
      bit got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (bus.req_ready != 2'b00) begin
          got = 1'b1;
          checkOutput("grant one-hot", WIDTH'(bus.req_ready), expG ? 2 : 1);
          sb.push_back('{id: expG, data: expG ? 32'hFFF0FFF0 : 32'h0F000F00, firstCyc: cyc + 1});
          expG = ~expG;
        end
      end
      if (!got) checkOutput("grant timeout", '0, 1);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
  endtask

  // Count consecutive busy cycles following an accept.
  task automatic countBusy(input int expCycles);
    int n = 0;
    bit stop = 1'b0;
    for (int k = 0; k < 20 && !stop; k++) begin
      @(negedge clk);
      if (bus.busy) n = n + 1;
      else stop = 1'b1;
    end
    checkOutput("busy cycles", WIDTH'(n), WIDTH'(expCycles));
  endtask

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (!bus.busy && sb.size() == 0) ok = 1'b1;
    end
    if (!ok) checkOutput("drain timeout", WIDTH'(sb.size()), '0);
  endtask

  // Global watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{idx: 1'b0, op: OP_NOT, a: 32'h0F0F0F0F, b: 32'h0, expData: 32'hF0F0F0F0, lat: 1};
    vecs[1] = '{idx: 1'b1, op: OP_NEG, a: 32'h00000001, b: 32'h0, expData: 32'hFFFFFFFF, lat: 2};
    vecs[2] = '{idx: 1'b1, op: OP_NEG, a: 32'h00000000, b: 32'h0, expData: 32'h00000000, lat: 2};
    vecs[3] = '{idx: 1'b1, op: OP_NEG, a: 32'h80000000, b: 32'h0, expData: 32'h80000000, lat: 2};
    vecs[4] = '{idx: 1'b0, op: OP_AND, a: 32'hFF00FF00, b: 32'h0FF00FF0, expData: 32'h0F000F00, lat: 1};
    vecs[5] = '{idx: 1'b1, op: OP_OR,  a: 32'hFF00FF00, b: 32'h0FF00FF0, expData: 32'hFFF0FFF0, lat: 1};
    vecs[6] = '{idx: 1'b0, op: OP_NEG, a: 32'hFFFFFFFF, b: 32'h0, expData: 32'h00000001, lat: 2};
    vecs[7] = '{idx: 1'b1, op: OP_NOT, a: 32'h00000000, b: 32'h5, expData: 32'hFFFFFFFF, lat: 1};

    bus.req_valid = 2'b11;
    bus.req_op0 = OP_NOT; bus.req_op1 = OP_NOT;
    bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with both requests asserted to show ready is forced low.
    #12;
    checkOutput("reset rsp_valid", WIDTH'(bus.rsp_valid), '0);
    checkOutput("reset busy", WIDTH'(bus.busy), '0);
    checkOutput("reset req_ready", WIDTH'(bus.req_ready), '0);
    checkOutput("reset rsp_data", bus.rsp_data, '0);
    checkOutput("reset rsp_id", WIDTH'(bus.rsp_id), '0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention right after reset: 0,1,0,1.
    applyBoth(4, 1'b0);
    waitIdle();

    // Single-request vectors with latency and busy-duration checks.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expData, vecs[i].lat);
      countBusy(vecs[i].lat);
      waitIdle();
    end

    // Backpressure: response held for 5 cycles while requester 1 waits, then
    // requester 1 withdraws without ever being granted.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, OP_NOT, 32'h12345678, 32'h0, 32'hEDCBA987, 1);
    bus.req_op1 = OP_NOT;
    bus.req_valid[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("held rsp_valid", WIDTH'(bus.rsp_valid), 1);
    end
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle after release", WIDTH'(bus.busy), '0);
    waitIdle();

    // Requester 0 withdraws while busy on a requester-1 NEG; last grant
    // must stay with requester 1, so a tie then goes to requester 0.
    applyStimulus(1'b1, OP_NEG, 32'h00000005, 32'h0, 32'hFFFFFFFB, 2);
    bus.req_op0 = OP_NOT;
    bus.req_valid[0] = 1'b1;
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    waitIdle();
    applyBoth(2, 1'b0);
    waitIdle();

    // Reset during NEG2 of a requester-0 op: outputs clear at once, the op
    // is dropped and arbitration restarts with requester 0.
    applyStimulus(1'b0, OP_NEG, 32'h00000007, 32'h0, 32'hFFFFFFF9, 2);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-op reset rsp_valid", WIDTH'(bus.rsp_valid), '0);
    checkOutput("mid-op reset busy", WIDTH'(bus.busy), '0);
    checkOutput("mid-op reset rsp_data", bus.rsp_data, '0);
    checkOutput("mid-op reset rsp_id", WIDTH'(bus.rsp_id), '0);
    checkOutput("mid-op reset req_ready", WIDTH'(bus.req_ready), '0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    applyBoth(1, 1'b0);
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
